// File: rtl/mem_lsu.sv
// Load/store unit over LANES byte-wide synchronous RAM banks; unaligned accesses may cross
// a row boundary and wrap from the top byte to address 0. One response per accepted request.
module mem_lsu #(
    parameter int unsigned SIZE_LOG2  = 13,
    parameter int unsigned LANES      = 4,
    parameter bit          MISALIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [SIZE_LOG2-1:0]   req_addr,
    input  logic [8*LANES-1:0]     req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [8*LANES-1:0]     resp_rdata,
    output logic                   resp_err
);

    localparam int unsigned DW    = 8 * LANES;
    localparam int unsigned OFFW  = $clog2(LANES);
    localparam int unsigned ROWW  = SIZE_LOG2 - OFFW;
    localparam int unsigned DEPTH = 1 << ROWW;

    typedef enum logic {StIdle, StResp} stateT;

    stateT stateQ, stateD;
    logic  accept;

    logic [ROWW-1:0]  reqRow;
    logic [OFFW-1:0]  reqOff;
    logic             sizeBad, misalign, reqErr;
    int unsigned      nReqBytes;

    logic [OFFW-1:0]  laneK     [LANES];
    logic [ROWW-1:0]  laneRow   [LANES];
    logic [7:0]       laneWdata [LANES];
    logic [LANES-1:0] laneWe;

    logic [DW-1:0]    bankRd, extData, holdQ, respData;
    logic             weQ, errQ, signedQ, firstQ;
    logic [1:0]       sizeQ;
    logic [OFFW-1:0]  offQ;

    logic [OFFW-1:0]  srcIdx  [LANES];
    logic [7:0]       rawByte [LANES];
    int unsigned      nBytes;
    logic             msb;
    logic [7:0]       fill;

    // req_ready depends only on state and resp_ready; rst gates acceptance so no bank
    // write can happen while reset is held.
    always_comb begin
        req_ready  = (stateQ == StIdle) || resp_ready;
        accept     = req_valid && req_ready && rst;
        resp_valid = (stateQ == StResp);
        stateD     = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) stateD = StResp;
            end
            StResp: begin
                if (accept) begin
                    stateD = StResp;
                end else if (resp_ready) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            2'd3:    misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
        sizeBad   = (req_size == 2'd3) && (LANES < 8);
        reqErr    = sizeBad || (!MISALIGNED && misalign);
        nReqBytes = 32'd1 << req_size;
        reqRow    = req_addr[SIZE_LOG2-1:OFFW];
        reqOff    = req_addr[OFFW-1:0];
    end

    // Lane l carries byte k = (l - offset) mod LANES; lanes below the offset belong to the
    // next row.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            laneK[l]     = OFFW'(l) - reqOff;
            laneRow[l]   = (OFFW'(l) >= reqOff) ? reqRow : reqRow + ROWW'(1);
            laneWdata[l] = req_wdata[8*laneK[l] +: 8];
            laneWe[l]    = accept && req_we && !reqErr && (32'(laneK[l]) < nReqBytes);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : gBank
        logic [7:0] mem [DEPTH];
        logic [7:0] rdQ;

        always_ff @(posedge clk) begin
            if (laneWe[l]) mem[laneRow[l]] <= laneWdata[l];
            if (accept)    rdQ <= mem[laneRow[l]];
        end

        assign bankRd[8*l +: 8] = rdQ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= StIdle;
            weQ     <= 1'b0;
            errQ    <= 1'b0;
            signedQ <= 1'b0;
            sizeQ   <= 2'd0;
            offQ    <= '0;
            firstQ  <= 1'b0;
            holdQ   <= '0;
        end else begin
            stateQ <= stateD;
            firstQ <= accept;
            if (accept) begin
                weQ     <= req_we;
                errQ    <= reqErr;
                signedQ <= req_signed;
                sizeQ   <= req_size;
                offQ    <= reqOff;
            end
            if (firstQ) holdQ <= extData;
        end
    end

    // Rotate bank outputs back to request byte order, then extend past the access width.
    always_comb begin
        nBytes  = 32'd1 << sizeQ;
        msb     = 1'b0;
        extData = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            srcIdx[k]  = offQ + OFFW'(k);
            rawByte[k] = bankRd[8*srcIdx[k] +: 8];
            if (k == nBytes - 1) msb = rawByte[k][7];
        end
        fill = (signedQ && msb) ? 8'hFF : 8'h00;
        for (int unsigned k = 0; k < LANES; k++) begin
            extData[8*k +: 8] = (k < nBytes) ? rawByte[k] : fill;
        end
    end

    // Bank outputs are only trusted in the first response cycle; stalls replay the hold copy.
    always_comb begin
        respData   = firstQ ? extData : holdQ;
        resp_rdata = (resp_valid && !weQ && !errQ) ? respData : '0;
        resp_err   = resp_valid && errQ;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised scoreboard bench for mem_lsu against a byte-array reference model,
// plus a second instance with unaligned accesses disabled.
module tb_mem_lsu;

    localparam int unsigned SIZE_LOG2 = 13;
    localparam int unsigned LANES     = 4;
    localparam int unsigned MEMSZ     = 1 << SIZE_LOG2;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        aReqValid, aReqReady, aWe, aSigned, aRespValid, aRespReady, aErr;
    logic [1:0]  aSize;
    logic [12:0] aAddr;
    logic [31:0] aWdata, aRdata;

    mem_lsu #(.SIZE_LOG2(SIZE_LOG2), .LANES(LANES), .MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_lsu #(.SIZE_LOG2(SIZE_LOG2), .LANES(LANES), .MISALIGNED(1'b0)) u_dutAl (
        .clk(clk), .rst(rst),
        .req_valid(aReqValid), .req_ready(aReqReady), .req_we(aWe),
        .req_size(aSize), .req_signed(aSigned), .req_addr(aAddr),
        .req_wdata(aWdata), .resp_valid(aRespValid), .resp_ready(aRespReady),
        .resp_rdata(aRdata), .resp_err(aErr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } expT;

    expT        expQ[$];
    logic [7:0] refMem [MEMSZ];
    int         checks   = 0;
    int         failures = 0;
    int         stallCnt = 0;
    bit         randReady = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: memory is a flat byte array; access touches 2^size bytes modulo memory size.
    function automatic expT model(input logic we, input logic [1:0] size, input logic sgn,
                                  input int unsigned addr, input logic [31:0] wdata);
        expT e;
        int unsigned n;
        longint unsigned v;
        e.rdata = 0;
        e.err   = (size == 2'd3);
        e.name  = "";
        if (e.err) return e;
        n = 1 << size;
        if (we) begin
            for (int unsigned k = 0; k < n; k++) refMem[(addr + k) % MEMSZ] = wdata[8*k +: 8];
        end else begin
            v = 0;
            for (int unsigned k = 0; k < n; k++)
                v = v | (longint'(refMem[(addr + k) % MEMSZ]) << (8 * k));
            if (sgn && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    task automatic doReq(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [12:0] addr, input logic [31:0] wdata);
        bit  acc;
        int  waitCyc;
        expT e;
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        acc = 0;
        waitCyc = 0;
        while (!acc) begin
            #4;
            acc = req_ready;
            if (acc) begin
                e = model(we, size, sgn, addr, wdata);
                e.name = $sformatf("%s sz%0d s%0d @0x%0h", we ? "wr" : "rd", size, sgn, addr);
                expQ.push_back(e);
            end
            @(posedge clk);
            if (!acc) begin
                waitCyc++;
                if (waitCyc > 200) begin
                    checks++; failures++;
                    $display("FAIL accept_timeout: got no acceptance, required one within 200");
                    break;
                end
                @(negedge clk);
            end
        end
        #1 req_valid = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (stallCnt > 0) begin
                resp_ready = 0;
                stallCnt--;
            end else begin
                resp_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: checks handshake rules and pops the scoreboard on every consumed response.
    initial begin
        bit          prevAcc = 0;
        bit          held = 0;
        logic [31:0] heldData = 0;
        logic        heldErr = 0;
        expT         e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                prevAcc = 0;
                held = 0;
            end else begin
                check("req_ready_rule", req_ready, !resp_valid || resp_ready);
                if (prevAcc) check("resp_latency", resp_valid, 1'b1);
                if (held && resp_valid) begin
                    check("stall_rdata_stable", resp_rdata, heldData);
                    check("stall_err_stable", resp_err, heldErr);
                end
                if (resp_valid && resp_ready) begin
                    if (expQ.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_response: got response, required none");
                    end else begin
                        e = expQ.pop_front();
                        check({e.name, " rdata"}, resp_rdata, e.rdata);
                        check({e.name, " err"}, resp_err, e.err);
                    end
                end
                held = resp_valid && !resp_ready;
                heldData = resp_rdata;
                heldErr = resp_err;
                prevAcc = req_valid && req_ready;
            end
        end
    end

    task automatic aReq(input logic we, input logic [1:0] size, input logic [12:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expData,
                        input logic expErr, input string name);
        @(negedge clk);
        aReqValid = 1; aWe = we; aSize = size; aAddr = addr; aWdata = wdata; aSigned = 0;
        #4 check({name, " ready"}, aReqReady, 1'b1);
        @(posedge clk);
        #1 aReqValid = 0;
        @(negedge clk);
        #4;
        check({name, " valid"}, aRespValid, 1'b1);
        check({name, " rdata"}, aRdata, expData);
        check({name, " err"}, aErr, expErr);
    endtask

    initial begin
        int waitCyc;
        for (int i = 0; i < int'(MEMSZ); i++) refMem[i] = 8'h00;
        rst = 0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        aReqValid = 0; aWe = 0; aSize = 0; aSigned = 0; aAddr = 0; aWdata = 0; aRespReady = 1;
        repeat (3) @(negedge clk);
        #1;
        check("reset resp_valid", resp_valid, 1'b0);
        check("reset resp_err", resp_err, 1'b0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset req_ready", req_ready, 1'b1);
        check("reset aligned resp_valid", aRespValid, 1'b0);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < int'(MEMSZ / 4); i++) doReq(1, 2, 0, 13'(4 * i), 32'h0);

        doReq(1, 2, 0, 13'h10, 32'hDEADBEEF);
        doReq(0, 2, 0, 13'h10, 32'h0);
        doReq(0, 0, 1, 13'h13, 32'h0);
        doReq(0, 1, 0, 13'h12, 32'h0);
        doReq(0, 1, 1, 13'h10, 32'h0);

        doReq(1, 2, 0, 13'h1E, 32'h11223344);
        doReq(0, 2, 0, 13'h1C, 32'h0);
        doReq(0, 2, 0, 13'h20, 32'h0);

        doReq(1, 2, 0, 13'h1FFE, 32'h01020304);
        doReq(0, 1, 0, 13'h0000, 32'h0);
        doReq(0, 1, 0, 13'h1FFE, 32'h0);

        doReq(1, 3, 0, 13'h10, 32'h55555555);
        doReq(0, 3, 1, 13'h10, 32'h0);
        doReq(0, 2, 0, 13'h10, 32'h0);

        // Backpressure: three stalled cycles on a read response.
        doReq(0, 2, 0, 13'h1C, 32'h0);
        stallCnt = 3;
        repeat (6) @(negedge clk);

        // Reset while a response is pending drops it at once.
        doReq(0, 2, 0, 13'h10, 32'h0);
        stallCnt = 5;
        @(negedge clk);
        #2 rst = 0;
        #1;
        check("async reset resp_valid", resp_valid, 1'b0);
        check("async reset resp_err", resp_err, 1'b0);
        check("async reset resp_rdata", resp_rdata, 32'h0);
        check("async reset req_ready", req_ready, 1'b1);
        expQ.delete();
        stallCnt = 0;
        @(negedge clk);
        rst = 1;
        doReq(0, 2, 0, 13'h10, 32'h0);
        doReq(0, 2, 0, 13'h1C, 32'h0);

        randReady = 1;
        for (int i = 0; i < 400; i++) begin
            logic [12:0] addr;
            logic [1:0]  size;
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? 13'(MEMSZ - 1 - $urandom_range(0, 15))
                                               : 13'($urandom_range(0, 63));
            doReq(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
        end
        randReady = 0;

        waitCyc = 0;
        while (expQ.size() != 0 && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d responses outstanding, required 0", expQ.size());
        end

        aReq(1, 2, 13'h0, 32'hCAFEF00D, 32'h0, 1'b0, "al wr word @0");
        aReq(1, 2, 13'h2, 32'hFFFFFFFF, 32'h0, 1'b1, "al misaligned wr word @2");
        aReq(0, 2, 13'h0, 32'h0, 32'hCAFEF00D, 1'b0, "al rd word @0");
        aReq(0, 1, 13'h1, 32'h0, 32'h0, 1'b1, "al misaligned rd half @1");
        aReq(0, 1, 13'h2, 32'h0, 32'h0000CAFE, 1'b0, "al rd half @2");
        aReq(0, 3, 13'h0, 32'h0, 32'h0, 1'b1, "al size3");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
